// File: rtl/fpu_issue_controller_pkg.sv
// Shared opcodes, FSM state encoding and helpers for the fixed-point issue/writeback stage.
package fpu_issue_controller_pkg;

  localparam logic [1:0] FPU_ADD     = 2'd0;
  localparam logic [1:0] FPU_SUB     = 2'd1;
  localparam logic [1:0] FPU_MUL     = 2'd2;
  localparam logic [1:0] FPU_SQRT    = 2'd3;
  // ADD doubles as the idle code: it parks the FPU's MUL/SQRT sequencers.
  localparam logic [1:0] FPU_IDLE_OP = FPU_ADD;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ARM  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/fpu_issue_controller_if.sv
// Decode-side request channel and writeback-side result channel of the FPU issue stage.
interface fpu_issue_controller_if #(
  parameter int WIDTH    = 32,
  parameter int RD_WIDTH = 5
);
  logic                req_valid;
  logic                req_ready;
  logic [1:0]          req_op;
  logic [WIDTH-1:0]    req_operand_1;
  logic [WIDTH-1:0]    req_operand_2;
  logic [RD_WIDTH-1:0] req_rd;

  logic                wb_valid;
  logic                wb_ready;
  logic [WIDTH-1:0]    wb_result;
  logic [RD_WIDTH-1:0] wb_rd;
  logic                wb_timeout;

  modport master (
    output req_valid, req_op, req_operand_1, req_operand_2, req_rd,
    input  req_ready,
    input  wb_valid, wb_result, wb_rd, wb_timeout,
    output wb_ready
  );

  modport slave (
    input  req_valid, req_op, req_operand_1, req_operand_2, req_rd,
    output req_ready,
    output wb_valid, wb_result, wb_rd, wb_timeout,
    input  wb_ready
  );
endinterface

// File: rtl/fpu_watchdog_counter.sv
// Per-op watchdog: counts stalled WAIT cycles and flags the abort point, saturating there.
module fpu_watchdog_counter
  import fpu_issue_controller_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic terminal
);
  localparam int             CW   = cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !terminal) begin
      count_reg <= count_reg + CW'(1);
    end
  end

  assign terminal = (count_reg == LAST);
endmodule

// File: rtl/fpu_issue_controller.sv
// Issues one fixed-point op at a time to the FPU, captures its result (or a watchdog abort)
// and holds it for writeback under backpressure.
module fpu_issue_controller
  import fpu_issue_controller_pkg::*;
#(
  parameter int WIDTH          = 32,
  parameter int RD_WIDTH       = 5,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  fpu_issue_controller_if.slave bus,
  output logic [WIDTH-1:0]      fpu_operand_1,
  output logic [WIDTH-1:0]      fpu_operand_2,
  output logic [1:0]            fpu_operation,
  input  logic [WIDTH-1:0]      fpu_result,
  input  logic                  fpu_ready,
  output logic                  busy
);
  state_t              state_reg, state_next;
  logic [1:0]          op_reg, op_next;
  logic [WIDTH-1:0]    operand_1_reg, operand_1_next;
  logic [WIDTH-1:0]    operand_2_reg, operand_2_next;
  logic [RD_WIDTH-1:0] rd_reg, rd_next;
  logic [WIDTH-1:0]    result_reg, result_next;
  logic                timeout_reg, timeout_next;
  logic                valid_reg, valid_next;
  logic                wd_clear, wd_enable, wd_terminal;

  // Counter only runs while waiting on a stalled FPU; any other state re-arms it.
  assign wd_clear  = (state_reg != ST_WAIT);
  assign wd_enable = (state_reg == ST_WAIT) && !fpu_ready;

  fpu_watchdog_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .reset   (reset),
    .clear   (wd_clear),
    .enable  (wd_enable),
    .terminal(wd_terminal)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= ST_IDLE;
      op_reg        <= FPU_IDLE_OP;
      operand_1_reg <= '0;
      operand_2_reg <= '0;
      rd_reg        <= '0;
      result_reg    <= '0;
      timeout_reg   <= 1'b0;
      valid_reg     <= 1'b0;
    end else begin
      state_reg     <= state_next;
      op_reg        <= op_next;
      operand_1_reg <= operand_1_next;
      operand_2_reg <= operand_2_next;
      rd_reg        <= rd_next;
      result_reg    <= result_next;
      timeout_reg   <= timeout_next;
      valid_reg     <= valid_next;
    end
  end

  // ARM always advances: fpu_ready there can be left over from the previous op.
  always_comb begin
    state_next = state_reg;
    if (flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (bus.req_valid) state_next = ST_ARM;
        ST_ARM:  state_next = ST_WAIT;
        ST_WAIT: if (fpu_ready || wd_terminal) state_next = ST_DONE;
        ST_DONE: if (bus.wb_ready) state_next = ST_IDLE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    op_next        = op_reg;
    operand_1_next = operand_1_reg;
    operand_2_next = operand_2_reg;
    rd_next        = rd_reg;
    result_next    = result_reg;
    timeout_next   = timeout_reg;
    valid_next     = valid_reg;
    if (flush) begin
      op_next    = FPU_IDLE_OP;
      valid_next = 1'b0;
    end else begin
      case (state_reg)
        ST_IDLE: begin
          if (bus.req_valid) begin
            op_next        = bus.req_op;
            operand_1_next = bus.req_operand_1;
            operand_2_next = bus.req_operand_2;
            rd_next        = bus.req_rd;
          end
        end
        ST_WAIT: begin
          // A ready pulse on the abort cycle still delivers the real result.
          if (fpu_ready) begin
            result_next  = fpu_result;
            timeout_next = 1'b0;
            op_next      = FPU_IDLE_OP;
            valid_next   = 1'b1;
          end else if (wd_terminal) begin
            result_next  = '0;
            timeout_next = 1'b1;
            op_next      = FPU_IDLE_OP;
            valid_next   = 1'b1;
          end
        end
        ST_DONE: begin
          if (bus.wb_ready) valid_next = 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.req_ready  = (state_reg == ST_IDLE);
  assign busy           = (state_reg != ST_IDLE);
  assign bus.wb_valid   = valid_reg;
  assign bus.wb_result  = result_reg;
  assign bus.wb_rd      = rd_reg;
  assign bus.wb_timeout = timeout_reg;
  assign fpu_operand_1  = operand_1_reg;
  assign fpu_operand_2  = operand_2_reg;
  assign fpu_operation  = op_reg;
endmodule

// File: tb/tb_fpu_issue_controller.sv
// Bench for fpu_issue_controller: stub FPU with programmable MUL/SQRT delay, directed cases
// plus randomized ops scored against an expected-result/latency model.
module tb_fpu_issue_controller;
  import fpu_issue_controller_pkg::*;

  localparam int WIDTH    = 32;
  localparam int RD_WIDTH = 5;
  localparam int TO       = 16;

  logic                clk = 1'b0;
  logic                reset;
  logic                flush;
  logic [WIDTH-1:0]    fpu_operand_1, fpu_operand_2, fpu_result;
  logic [1:0]          fpu_operation;
  logic                fpu_ready;
  logic                busy;

  fpu_issue_controller_if #(.WIDTH(WIDTH), .RD_WIDTH(RD_WIDTH)) bus ();

  fpu_issue_controller #(
    .WIDTH(WIDTH), .RD_WIDTH(RD_WIDTH), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .reset(reset), .flush(flush), .bus(bus),
    .fpu_operand_1(fpu_operand_1), .fpu_operand_2(fpu_operand_2),
    .fpu_operation(fpu_operation), .fpu_result(fpu_result),
    .fpu_ready(fpu_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Q22.10 arithmetic
  function automatic logic [WIDTH-1:0] fx_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [63:0] p;
    p = 64'(a) * 64'(b);
    return p[WIDTH+9:10];
  endfunction

  function automatic logic [WIDTH-1:0] fx_sqrt(input logic [WIDTH-1:0] a);
    logic [63:0] x, r, t;
    x = 64'(a) << 10;
    r = '0;
    for (int bit_i = 31; bit_i >= 0; bit_i--) begin
      t = r | (64'd1 << bit_i);
      if (t * t <= x) r = t;
    end
    return r[WIDTH-1:0];
  endfunction

  // Stub FPU: ADD/SUB combinational; MUL/SQRT pulse ready on the stub_delay-th cycle after
  // the cycle the op first appears; a non-MUL/SQRT code resets the sequencer.
  int seq_cnt;
  int stub_delay = 1;
  bit stub_dead  = 1'b0;

  always @(posedge clk or posedge reset) begin
    if (reset) seq_cnt <= 0;
    else if (fpu_operation == FPU_MUL || fpu_operation == FPU_SQRT) seq_cnt <= seq_cnt + 1;
    else seq_cnt <= 0;
  end

  always_comb begin
    fpu_result = '0;
    fpu_ready  = 1'b0;
    case (fpu_operation)
      FPU_ADD: begin fpu_result = fpu_operand_1 + fpu_operand_2; fpu_ready = !stub_dead; end
      FPU_SUB: begin fpu_result = fpu_operand_1 - fpu_operand_2; fpu_ready = !stub_dead; end
      FPU_MUL: begin
        fpu_result = fx_mul(fpu_operand_1, fpu_operand_2);
        fpu_ready  = !stub_dead && (seq_cnt == stub_delay);
      end
      default: begin
        fpu_result = fx_sqrt(fpu_operand_1);
        fpu_ready  = !stub_dead && (seq_cnt == stub_delay);
      end
    endcase
  end

  task automatic accept_op(input logic [1:0] op, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic [RD_WIDTH-1:0] rd);
    int w;
    w = 0;
    bus.req_op        = op;
    bus.req_operand_1 = a;
    bus.req_operand_2 = b;
    bus.req_rd        = rd;
    bus.req_valid     = 1'b1;
    while (!bus.req_ready && w < 8) begin
      @(posedge clk); #1;
      w++;
    end
    check("req_ready_seen", 64'(bus.req_ready), 64'd1);
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  int txn_id = 0;

  task automatic run_op(input logic [1:0] op, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                        input logic [RD_WIDTH-1:0] rd, input int delay, input bit dead, input int stall);
    logic [WIDTH-1:0] exp_res;
    bit               exp_to;
    int               exp_lat, n, ready_at;
    stub_delay = delay;
    stub_dead  = dead;
    case (op)
      FPU_ADD: exp_res = a + b;
      FPU_SUB: exp_res = a - b;
      FPU_MUL: exp_res = fx_mul(a, b);
      default: exp_res = fx_sqrt(a);
    endcase
    ready_at = (op == FPU_ADD || op == FPU_SUB) ? 1 : delay;
    if (dead || ready_at > TO) begin
      exp_to = 1'b1; exp_res = '0; exp_lat = TO + 2;
    end else begin
      exp_to = 1'b0; exp_lat = ready_at + 2;
    end

    accept_op(op, a, b, rd);
    n = 1;
    while (!bus.wb_valid && n < TO + 8) begin
      check("op_held", 64'(fpu_operation), 64'(op));
      check("opnd_held", 64'(fpu_operand_1), 64'(a));
      check("req_ready_busy", 64'(bus.req_ready), 64'd0);
      @(posedge clk); #1;
      n++;
    end
    check("wb_valid_seen", 64'(bus.wb_valid), 64'd1);
    if (!bus.wb_valid) begin
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      return;
    end
    check("latency", 64'(n), 64'(exp_lat));
    check("wb_result", 64'(bus.wb_result), 64'(exp_res));
    check("wb_rd", 64'(bus.wb_rd), 64'(rd));
    check("wb_timeout", 64'(bus.wb_timeout), 64'(exp_to));
    check("done_idle_op", 64'(fpu_operation), 64'(FPU_IDLE_OP));
    $display("txn %0d op=%0d a=%h b=%h rd=%0d delay=%0d dead=%0d stall=%0d lat=%0d res=%h to=%0d",
             txn_id, op, a, b, rd, delay, dead, stall, n, bus.wb_result, bus.wb_timeout);
    txn_id++;
    for (int i = 0; i < stall; i++) begin
      @(posedge clk); #1;
      check("stall_valid", 64'(bus.wb_valid), 64'd1);
      check("stall_result", 64'(bus.wb_result), 64'(exp_res));
      check("stall_rd", 64'(bus.wb_rd), 64'(rd));
      check("stall_req_ready", 64'(bus.req_ready), 64'd0);
    end
    bus.wb_ready = 1'b1;
    @(posedge clk); #1;
    bus.wb_ready = 1'b0;
    check("release_valid", 64'(bus.wb_valid), 64'd0);
    check("release_req_ready", 64'(bus.req_ready), 64'd1);
  endtask

  initial begin
    reset             = 1'b1;
    flush             = 1'b0;
    bus.req_valid     = 1'b0;
    bus.req_op        = FPU_ADD;
    bus.req_operand_1 = '0;
    bus.req_operand_2 = '0;
    bus.req_rd        = '0;
    bus.wb_ready      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_req_ready", 64'(bus.req_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("rst_wb_result", 64'(bus.wb_result), 64'd0);
    check("rst_wb_rd", 64'(bus.wb_rd), 64'd0);
    check("rst_wb_timeout", 64'(bus.wb_timeout), 64'd0);
    check("rst_fpu_op", 64'(fpu_operation), 64'(FPU_ADD));
    check("rst_operands", 64'({fpu_operand_1, fpu_operand_2}), 64'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed examples, back-to-back SQRT, backpressure and watchdog boundaries
    run_op(FPU_ADD,  32'h0000_0C00, 32'h0000_0400, 5'd5, 1, 1'b0, 0);
    check("add_value", 64'(bus.wb_result), 64'h1000);
    run_op(FPU_MUL,  32'h0000_0800, 32'h0000_0C00, 5'd7, 4, 1'b0, 0);
    run_op(FPU_SQRT, 32'h0000_1000, 32'h0, 5'd9, 3, 1'b0, 0);
    run_op(FPU_SQRT, 32'h0000_2400, 32'h0, 5'd10, 3, 1'b0, 0);
    run_op(FPU_SUB,  32'h0000_5000, 32'h0000_1400, 5'd11, 1, 1'b0, 10);
    run_op(FPU_MUL,  32'h0000_0C00, 32'h0000_0C00, 5'd12, 1, 1'b1, 2);
    run_op(FPU_ADD,  32'h0000_0001, 32'h0000_0002, 5'd13, 1, 1'b1, 0);
    run_op(FPU_MUL,  32'h0000_0400, 32'h0000_0400, 5'd14, TO, 1'b0, 0);
    run_op(FPU_SQRT, 32'h0000_1000, 32'h0, 5'd15, TO + 1, 1'b0, 0);

    // Async reset in the middle of a SQRT
    stub_dead  = 1'b0;
    stub_delay = 50;
    accept_op(FPU_SQRT, 32'h0000_1000, 32'h0, 5'd21);
    repeat (3) begin @(posedge clk); #1; end
    reset = 1'b1;
    #1;
    check("midrst_req_ready", 64'(bus.req_ready), 64'd1);
    check("midrst_busy", 64'(busy), 64'd0);
    check("midrst_wb_valid", 64'(bus.wb_valid), 64'd0);
    check("midrst_fpu_op", 64'(fpu_operation), 64'(FPU_ADD));
    check("midrst_wb_rd", 64'(bus.wb_rd), 64'd0);
    check("midrst_wb_result", 64'(bus.wb_result), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    run_op(FPU_ADD, 32'h0000_0C00, 32'h0000_0400, 5'd3, 1, 1'b0, 0);

    // Synchronous flush in the middle of a MUL
    stub_delay = 10;
    accept_op(FPU_MUL, 32'h0000_0800, 32'h0000_0C00, 5'd22);
    repeat (2) begin @(posedge clk); #1; end
    flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", 64'(busy), 64'd0);
    check("flush_fpu_op", 64'(fpu_operation), 64'(FPU_ADD));
    for (int i = 0; i < 12; i++) begin
      check("flush_no_wb", 64'(bus.wb_valid), 64'd0);
      @(posedge clk); #1;
    end
    run_op(FPU_ADD, 32'h0000_0C00, 32'h0000_0400, 5'd4, 1, 1'b0, 0);

    // Flush beats a simultaneous request in IDLE
    flush         = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_op    = FPU_MUL;
    @(posedge clk); #1;
    flush         = 1'b0;
    bus.req_valid = 1'b0;
    check("flush_vs_req_busy", 64'(busy), 64'd0);
    check("flush_vs_req_op", 64'(fpu_operation), 64'(FPU_ADD));

    // Randomized ops
    for (int t = 0; t < 40; t++) begin
      logic [1:0]          r_op;
      logic [WIDTH-1:0]    r_a, r_b;
      logic [RD_WIDTH-1:0] r_rd;
      r_op = 2'($urandom_range(0, 3));
      r_a  = $urandom;
      r_b  = $urandom;
      r_rd = RD_WIDTH'($urandom_range(0, 31));
      run_op(r_op, r_a, r_b, r_rd, $urandom_range(1, TO + 2),
             ($urandom_range(0, 9) == 0), $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
